// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (addu, subu, ori, lw, sw, beq, lui, j, jal).
// Drives the ALU op select (00 add, 01 sub, 10 or, 11 lui-shift), the datapath
// write enables and the mux selects. Uses the ALU zero flag for beq.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   opcode, funct         IR[31:26], IR[5:0] (sampled while in DECODE)
//   zero                  ALU zero flag
//   pcwr irwr regwr memwr write enables
//   iord alusrca alusrcb extop aluop regdst wdsel pcsrc   datapath selects
//   state                 current FSM state (debug)
// ILLEGAL_HALT: 0 -> unknown instruction returns to FETCH, 1 -> park in HALT.
module mc_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcwr,
  output logic       irwr,
  output logic       regwr,
  output logic       memwr,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [1:0] aluop,
  output logic [1:0] regdst,
  output logic [1:0] wdsel,
  output logic [1:0] pcsrc,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                         S_EXE    = 4'd6,  S_ALUWB  = 4'd7,  S_BRANCH = 4'd8,
                         S_JUMP   = 4'd9,  S_HALT   = 4'd15;

  // Instruction class, latched at the end of DECODE so later IR changes are ignored.
  localparam logic [3:0] C_NOP = 4'd0, C_ADDU = 4'd1, C_SUBU = 4'd2, C_ORI = 4'd3,
                         C_LW  = 4'd4, C_SW   = 4'd5, C_BEQ  = 4'd6, C_LUI = 4'd7,
                         C_J   = 4'd8, C_JAL  = 4'd9, C_ILL  = 4'd10;

  logic [3:0] st, st_nx, cls, dec;

  always_comb begin
    dec = C_ILL;
    case (opcode)
      6'b000000: begin
        if (funct == 6'b100001)      dec = C_ADDU;
        else if (funct == 6'b100011) dec = C_SUBU;
      end
      6'b001101: dec = C_ORI;
      6'b100011: dec = C_LW;
      6'b101011: dec = C_SW;
      6'b000100: dec = C_BEQ;
      6'b001111: dec = C_LUI;
      6'b000010: dec = C_J;
      6'b000011: dec = C_JAL;
      default:   dec = C_ILL;
    endcase
  end

  always_comb begin
    st_nx = S_FETCH;
    case (st)
      S_FETCH:  st_nx = S_DECODE;
      S_DECODE: begin
        case (dec)
          C_LW, C_SW:                   st_nx = S_MEMADR;
          C_ADDU, C_SUBU, C_ORI, C_LUI: st_nx = S_EXE;
          C_BEQ:                        st_nx = S_BRANCH;
          C_J, C_JAL:                   st_nx = S_JUMP;
          default:                      st_nx = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: st_nx = (cls == C_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  st_nx = S_MEMWB;
      S_EXE:    st_nx = S_ALUWB;
      S_HALT:   st_nx = S_HALT;
      default:  st_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= S_FETCH;
      cls <= C_NOP;
    end else begin
      st <= st_nx;
      if (st == S_DECODE) cls <= dec;
    end
  end

  always_comb begin
    pcwr = 1'b0; irwr = 1'b0; regwr = 1'b0; memwr = 1'b0; iord = 1'b0;
    alusrca = 1'b0; alusrcb = 2'b00; extop = 1'b0; aluop = 2'b00;
    regdst = 2'b00; wdsel = 2'b00; pcsrc = 2'b00;
    case (st)
      S_FETCH:  begin irwr = 1'b1; pcwr = 1'b1; alusrcb = 2'b01; end
      S_DECODE: begin alusrcb = 2'b11; extop = 1'b1; end
      S_MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; extop = 1'b1; end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB:  begin regwr = 1'b1; wdsel = 2'b01; end
      S_MEMWR:  begin iord = 1'b1; memwr = 1'b1; end
      S_EXE, S_ALUWB: begin
        // ALU controls stay driven through write-back so ALUOut is stable.
        alusrca = 1'b1;
        case (cls)
          C_SUBU: aluop = 2'b01;
          C_ORI:  begin alusrcb = 2'b10; aluop = 2'b10; end
          C_LUI:  begin alusrcb = 2'b10; aluop = 2'b11; end
          default: ;
        endcase
        if (st == S_ALUWB) begin
          regwr  = 1'b1;
          regdst = (cls == C_ADDU || cls == C_SUBU) ? 2'b01 : 2'b00;
        end
      end
      S_BRANCH: begin
        alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01;
        pcwr = zero;
      end
      S_JUMP: begin
        pcsrc = 2'b10; pcwr = 1'b1;
        // PC already holds PC+4 here, which is the jal link value.
        if (cls == C_JAL) begin regwr = 1'b1; regdst = 2'b10; wdsel = 2'b10; end
      end
      default: ;
    endcase
    // Reset blanks every output immediately, suppressing any in-flight write.
    if (reset) begin
      pcwr = 1'b0; irwr = 1'b0; regwr = 1'b0; memwr = 1'b0; iord = 1'b0;
      alusrca = 1'b0; alusrcb = 2'b00; extop = 1'b0; aluop = 2'b00;
      regdst = 2'b00; wdsel = 2'b00; pcsrc = 2'b00;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: one instance per ILLEGAL_HALT setting on shared stimulus.
// Per-cycle vector table feeds a scoreboard queue; hand sequences cover the
// async-reset write suppression and zero toggling inside BRANCH.
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic       zero = 1'b0;

  logic       pcwr0, irwr0, regwr0, memwr0, iord0, alusrca0, extop0;
  logic [1:0] alusrcb0, aluop0, regdst0, wdsel0, pcsrc0;
  logic [3:0] state0;
  logic       pcwr1, irwr1, regwr1, memwr1, iord1, alusrca1, extop1;
  logic [1:0] alusrcb1, aluop1, regdst1, wdsel1, pcsrc1;
  logic [3:0] state1;

  mc_ctrl #(.ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pcwr(pcwr0), .irwr(irwr0), .regwr(regwr0), .memwr(memwr0), .iord(iord0),
    .alusrca(alusrca0), .alusrcb(alusrcb0), .extop(extop0), .aluop(aluop0),
    .regdst(regdst0), .wdsel(wdsel0), .pcsrc(pcsrc0), .state(state0));

  mc_ctrl #(.ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pcwr(pcwr1), .irwr(irwr1), .regwr(regwr1), .memwr(memwr1), .iord(iord1),
    .alusrca(alusrca1), .alusrcb(alusrcb1), .extop(extop1), .aluop(aluop1),
    .regdst(regdst1), .wdsel(wdsel1), .pcsrc(pcsrc1), .state(state1));

  always #5 clk = ~clk;

  logic [20:0] o0, o1;
  assign o0 = {pcwr0, irwr0, regwr0, memwr0, iord0, alusrca0, alusrcb0, extop0,
               aluop0, regdst0, wdsel0, pcsrc0, state0};
  assign o1 = {pcwr1, irwr1, regwr1, memwr1, iord1, alusrca1, alusrcb1, extop1,
               aluop1, regdst1, wdsel1, pcsrc1, state1};

  function automatic logic [20:0] mk(input logic pw, iw, rw, mw, io, asa,
                                     input logic [1:0] asb, input logic ex,
                                     input logic [1:0] aop, rd, wd, ps,
                                     input logic [3:0] st);
    return {pw, iw, rw, mw, io, asa, asb, ex, aop, rd, wd, ps, st};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op, fn;
    logic        z;
    logic [20:0] e0, e1;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [41:0] sb[$];
  int          errors = 0, checks = 0;

  task automatic add(input logic r, input logic [5:0] op, fn, input logic z,
                     input logic [20:0] e0, e1, input string nm);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.e0 = e0; v.e1 = e1; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [20:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  logic [20:0] Z, F, D, MA, MR, MWB, MW, EXS, WBS, EXA, WBA, EXO, WBO, EXL, WBL;
  logic [20:0] BR1, BR0, JP, JAL, HLT;

  initial begin
    Z   = '0;
    F   = mk(1,1,0,0,0,0,2'b01,0,2'b00,2'b00,2'b00,2'b00,4'd0);
    D   = mk(0,0,0,0,0,0,2'b11,1,2'b00,2'b00,2'b00,2'b00,4'd1);
    MA  = mk(0,0,0,0,0,1,2'b10,1,2'b00,2'b00,2'b00,2'b00,4'd2);
    MR  = mk(0,0,0,0,1,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'd3);
    MWB = mk(0,0,1,0,0,0,2'b00,0,2'b00,2'b00,2'b01,2'b00,4'd4);
    MW  = mk(0,0,0,1,1,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'd5);
    EXS = mk(0,0,0,0,0,1,2'b00,0,2'b01,2'b00,2'b00,2'b00,4'd6);
    WBS = mk(0,0,1,0,0,1,2'b00,0,2'b01,2'b01,2'b00,2'b00,4'd7);
    EXA = mk(0,0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'd6);
    WBA = mk(0,0,1,0,0,1,2'b00,0,2'b00,2'b01,2'b00,2'b00,4'd7);
    EXO = mk(0,0,0,0,0,1,2'b10,0,2'b10,2'b00,2'b00,2'b00,4'd6);
    WBO = mk(0,0,1,0,0,1,2'b10,0,2'b10,2'b00,2'b00,2'b00,4'd7);
    EXL = mk(0,0,0,0,0,1,2'b10,0,2'b11,2'b00,2'b00,2'b00,4'd6);
    WBL = mk(0,0,1,0,0,1,2'b10,0,2'b11,2'b00,2'b00,2'b00,4'd7);
    BR1 = mk(1,0,0,0,0,1,2'b00,0,2'b01,2'b00,2'b00,2'b01,4'd8);
    BR0 = mk(0,0,0,0,0,1,2'b00,0,2'b01,2'b00,2'b00,2'b01,4'd8);
    JP  = mk(1,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b10,4'd9);
    JAL = mk(1,0,1,0,0,0,2'b00,0,2'b00,2'b10,2'b10,2'b10,4'd9);
    HLT = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'd15);

    // reset held 3 cycles
    add(1, 6'h23, 6'h00, 0, Z, Z, "rst");
    add(1, 6'h23, 6'h00, 0, Z, Z, "rst");
    add(1, 6'h23, 6'h00, 0, Z, Z, "rst");
    // lw; opcode scrambled after DECODE to prove the latched class governs
    add(0, 6'h23, 6'h00, 0, F,   F,   "lw_fetch");
    add(0, 6'h23, 6'h00, 0, D,   D,   "lw_decode");
    add(0, 6'h2B, 6'h00, 0, MA,  MA,  "lw_memadr");
    add(0, 6'h3F, 6'h00, 0, MR,  MR,  "lw_memrd");
    add(0, 6'h3F, 6'h00, 0, MWB, MWB, "lw_memwb");
    // subu
    add(0, 6'h00, 6'h23, 0, F,   F,   "subu_fetch");
    add(0, 6'h00, 6'h23, 0, D,   D,   "subu_decode");
    add(0, 6'h00, 6'h21, 0, EXS, EXS, "subu_exe");
    add(0, 6'h0D, 6'h21, 0, WBS, WBS, "subu_aluwb");
    // beq taken, then not taken
    add(0, 6'h04, 6'h00, 1, F,   F,   "beq1_fetch");
    add(0, 6'h04, 6'h00, 1, D,   D,   "beq1_decode");
    add(0, 6'h04, 6'h00, 1, BR1, BR1, "beq1_branch");
    add(0, 6'h04, 6'h00, 0, F,   F,   "beq0_fetch");
    add(0, 6'h04, 6'h00, 0, D,   D,   "beq0_decode");
    add(0, 6'h04, 6'h00, 0, BR0, BR0, "beq0_branch");
    // jal
    add(0, 6'h03, 6'h00, 0, F,   F,   "jal_fetch");
    add(0, 6'h03, 6'h00, 0, D,   D,   "jal_decode");
    add(0, 6'h02, 6'h00, 0, JAL, JAL, "jal_jump");
    // lui
    add(0, 6'h0F, 6'h00, 0, F,   F,   "lui_fetch");
    add(0, 6'h0F, 6'h00, 0, D,   D,   "lui_decode");
    add(0, 6'h0F, 6'h00, 0, EXL, EXL, "lui_exe");
    add(0, 6'h0F, 6'h00, 0, WBL, WBL, "lui_aluwb");
    // ori
    add(0, 6'h0D, 6'h00, 0, F,   F,   "ori_fetch");
    add(0, 6'h0D, 6'h00, 0, D,   D,   "ori_decode");
    add(0, 6'h0D, 6'h00, 0, EXO, EXO, "ori_exe");
    add(0, 6'h0D, 6'h00, 0, WBO, WBO, "ori_aluwb");
    // addu
    add(0, 6'h00, 6'h21, 0, F,   F,   "addu_fetch");
    add(0, 6'h00, 6'h21, 0, D,   D,   "addu_decode");
    add(0, 6'h00, 6'h21, 0, EXA, EXA, "addu_exe");
    add(0, 6'h00, 6'h21, 0, WBA, WBA, "addu_aluwb");
    // j
    add(0, 6'h02, 6'h00, 0, F,   F,   "j_fetch");
    add(0, 6'h02, 6'h00, 0, D,   D,   "j_decode");
    add(0, 6'h03, 6'h00, 0, JP,  JP,  "j_jump");
    // sw
    add(0, 6'h2B, 6'h00, 0, F,   F,   "sw_fetch");
    add(0, 6'h2B, 6'h00, 0, D,   D,   "sw_decode");
    add(0, 6'h2B, 6'h00, 0, MA,  MA,  "sw_memadr");
    add(0, 6'h2B, 6'h00, 0, MW,  MW,  "sw_memwr");
    // illegal opcode: dut0 back to FETCH, dut1 parks
    add(0, 6'h3F, 6'h00, 0, F,   F,   "ill_fetch");
    add(0, 6'h3F, 6'h00, 0, D,   D,   "ill_decode");
    // unknown R-type funct
    add(0, 6'h00, 6'h00, 0, F,   HLT, "ill_after");
    add(0, 6'h00, 6'h00, 0, D,   HLT, "illr_decode");
    add(0, 6'h00, 6'h00, 0, F,   HLT, "illr_after");
    add(0, 6'h00, 6'h00, 0, Z,   Z,   "halt_rst");
    add(0, 6'h00, 6'h00, 0, F,   F,   "halt_release");
    // make the halt_rst row actually reset
    tbl[tbl.size()-2].rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      reset = tbl[i].rst; opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z;
      sb.push_back({tbl[i].e0, tbl[i].e1});
      @(negedge clk);
      begin
        logic [41:0] e;
        e = sb.pop_front();
        cmp({tbl[i].name, "/h0"}, o0, e[41:21]);
        cmp({tbl[i].name, "/h1"}, o1, e[20:0]);
      end
    end

    // beq: pcwr follows zero combinationally inside BRANCH
    @(posedge clk); #1 reset = 1'b0; opcode = 6'h04; zero = 1'b0;  // DECODE
    @(posedge clk); #1;                                             // BRANCH
    cmp("br_z0_h0", {20'd0, pcwr0}, 21'd0);
    zero = 1'b1; #1;
    cmp("br_z1_h0", {20'd0, pcwr0}, 21'd1);
    cmp("br_z1_h1", {20'd0, pcwr1}, 21'd1);
    zero = 1'b0; #1;
    cmp("br_zback_h0", {20'd0, pcwr0}, 21'd0);
    zero = 1'b1;
    @(posedge clk); #1;
    cmp("br_next_fetch", {17'd0, state0}, 21'd0);

    // sw with reset asserted during MEMWR: write suppressed at once
    opcode = 6'h2B;
    @(posedge clk); @(posedge clk); @(posedge clk); #2;             // MEMWR
    cmp("sw_memwr_on",  o0, MW);
    cmp("sw_memwr_on1", o1, MW);
    reset = 1'b1; #1;
    cmp("sw_rst_h0", o0, Z);
    cmp("sw_rst_h1", o1, Z);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    cmp("sw_release", o0, F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
